fetch_queue_unit: RTL and testbench

Parametrised instruction fetch unit: a wrapping fetch-PC counter drives a synchronous-read instruction memory. Returned words go into a small prefetch queue, each tagged with its PC. The decode stage drains the queue through a valid/ready handshake. It supersedes the single-register fetch stage and adds back-pressure, prefetch buffering and control-flow redirect with flush, between instruction memory and decode.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_queue_unit_sync_fifo_flush.sv | 49 ++++
 rtl/fetch_queue_unit.sv | 89 ++++++++
 tb/tb_fetch_queue_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults for the fetch queue unit.
// Queue entries carry {pc, instruction}.
package fetch_pkg;
  localparam int ADDR_W_D = 8;
  localparam int INSTR_W_D = 16;
  localparam int DEPTH_D = 4;
  localparam int unsigned RESET_PC_D = 0;
  localparam int ENTRY_W_D = ADDR_W_D + INSTR_W_D;
endpackage

// File: rtl/fetch_queue_unit_sync_fifo_flush.sv
// Circular-buffer FIFO with single-cycle flush.
// Pointers wrap naturally because DEPTH is a power of two.
import fetch_pkg::*;

module sync_fifo_flush #(
  parameter int WIDTH = ENTRY_W_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (reset && !flush && push)
      buf_q[wr_ptr] <= din;
  end

  assign head = buf_q[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC, one-deep in-flight tracking and
// prefetch queue feeding decode.
import fetch_pkg::*;

module fetch_queue_unit #(
  parameter int          ADDR_W   = ADDR_W_D,
  parameter int          INSTR_W  = INSTR_W_D,
  parameter int          DEPTH    = DEPTH_D,
  parameter int unsigned RESET_PC = RESET_PC_D
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int EW = ADDR_W + INSTR_W;
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] ifpc;
  logic              inflight;
  logic              started;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              have;
  logic              pop;
  logic              push;
  logic [CW:0]       occ;

  // issue, handshake and output muxing
  always_comb begin
    have        = reset && (count != '0);
    pop         = have && instr_ready && !redirect_valid;
    push        = inflight && !redirect_valid;
    occ         = {1'b0, count} + (CW+1)'(inflight)
                - (CW+1)'(pop);
    mem_req     = reset && started && !redirect_valid
                && (occ < (CW+1)'(DEPTH));
    mem_addr    = fpc;
    instr_valid = have;
    instr       = have ? head[INSTR_W-1:0] : '0;
    instr_pc    = have ? head[EW-1:INSTR_W] : '0;
  end

  // fetch PC and in-flight request tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc      <= ADDR_W'(RESET_PC);
      ifpc     <= '0;
      inflight <= 1'b0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        fpc      <= redirect_pc;
        inflight <= 1'b0;
      end else begin
        inflight <= mem_req;
        if (mem_req) begin
          fpc  <= fpc + ADDR_W'(1);
          ifpc <= fpc;
        end
      end
    end
  end

  sync_fifo_flush #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({ifpc, mem_rdata}),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus
// random traffic against a fetch-order scoreboard.
module tb_fetch_queue_unit;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  logic          mem_req, mem_req2;
  logic [AW-1:0] mem_addr, mem_addr2;
  logic [IW-1:0] mem_rdata = '0, mem_rdata2 = '0;
  logic          instr_valid, instr_valid2;
  logic [IW-1:0] instr, instr2;
  logic [AW-1:0] instr_pc, instr_pc2;

  logic [IW-1:0] mem [256];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_queue_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  fetch_queue_unit #(.RESET_PC(32'hFE)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req2),
    .mem_addr       (mem_addr2),
    .mem_rdata      (mem_rdata2),
    .instr_valid    (instr_valid2),
    .instr_ready    (1'b1),
    .instr          (instr2),
    .instr_pc       (instr_pc2),
    .redirect_valid (1'b0),
    .redirect_pc    (8'h00)
  );

  // 1-cycle latency instruction memories
  always @(posedge clk) begin
    if (mem_req)
      mem_rdata <= mem[mem_addr];
    if (mem_req2)
      mem_rdata2 <= mem[mem_addr2];
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference: fetch stream order and occupancy
  int            ago = -100;
  int            outs = 0;
  logic [AW-1:0] exp_pc = '0;
  logic [AW-1:0] exp_fetch = '0;
  logic          exp_req;
  logic          pop;

  always @(negedge clk) begin
    ago++;
    pop = reset && instr_valid && instr_ready
          && !redirect_valid;
    if (!instr_valid) begin
      check("idle_instr", instr, 0);
      check("idle_pc", instr_pc, 0);
    end
    if (reset && ago >= 3)
      check("stream_valid", instr_valid, 1);
    exp_req = reset && !redirect_valid && ago >= 1
              && (outs - int'(pop) < DP);
    check("mem_req", mem_req, exp_req);
    if (exp_req)
      check("mem_addr", mem_addr, exp_fetch);
    if (pop) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_instr", instr, mem[exp_pc]);
      exp_pc++;
    end
    if (!reset) begin
      ago = -1;
      outs = 0;
      exp_pc = '0;
      exp_fetch = '0;
    end else if (redirect_valid) begin
      ago = 0;
      outs = 0;
      exp_pc = redirect_pc;
      exp_fetch = redirect_pc;
    end else begin
      outs = outs + int'(exp_req) - int'(pop);
      if (exp_req)
        exp_fetch++;
    end
  end

  // reference for the wrap-around instance
  logic [AW-1:0] exp2 = 8'hFE;

  always @(negedge clk) begin
    if (!reset) begin
      exp2 = 8'hFE;
    end else if (instr_valid2) begin
      check("wrap_pc", instr_pc2, exp2);
      check("wrap_instr", instr2, mem[exp2]);
      exp2++;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 16'h1000 + 16'(i);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_req", mem_req, 0);

    // release: issue after E0, valid after E2
    @(posedge clk) #1;
    reset = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("e0_req", mem_req, 1);
    check("e0_addr", mem_addr, 0);
    check("e0_valid", instr_valid, 0);
    @(negedge clk);
    check("e1_valid", instr_valid, 0);
    @(negedge clk);
    check("e2_valid", instr_valid, 1);
    check("e2_pc", instr_pc, 0);
    check("e2_instr", instr, 16'h1000);
    repeat (8) @(posedge clk);

    // backpressure
    #1 instr_ready = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_req", mem_req, 0);
    check("bp_valid", instr_valid, 1);
    @(posedge clk) #1;
    instr_ready = 1'b1;
    repeat (8) @(posedge clk);

    // redirect with words queued and in flight
    #1 instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    @(posedge clk) #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check("rd_valid", instr_valid, 0);
    check("rd_req", mem_req, 1);
    check("rd_addr", mem_addr, 8'h40);
    @(negedge clk);
    @(negedge clk);
    check("rd_first_pc", instr_pc, 8'h40);
    check("rd_first_instr", instr, 16'h1040);
    repeat (6) @(posedge clk);

    // redirect from a full queue
    #1 instr_ready = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hC0;
    @(posedge clk) #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (6) @(posedge clk);

    // mid-stream reset for one edge
    #1 instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_valid", instr_valid, 0);
    check("mr_req", mem_req, 0);
    @(posedge clk) #1;
    reset = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_req2", mem_req, 1);
    check("mr_addr", mem_addr, 0);
    repeat (6) @(posedge clk);

    // redirect with ready=1 on a one-deep queue
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    @(posedge clk) #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rr_valid", instr_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check("rr_pc", instr_pc, 8'h80);
    check("rr_instr", instr, 16'h1080);

    // random traffic
    repeat (500) begin
      @(posedge clk) #1;
      instr_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = 8'($urandom);
      reset = ($urandom % 150) != 0;
    end
    @(posedge clk) #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
